// File: rtl/game_pkg.sv
// Shared definitions for the runner game: game-state encodings, rex/obstacle
// geometry used by the datapaths and renderer, and the obstacle-period helper.
package game_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        PLAYING = 2'd1,
        HOLD    = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    // Rex occupies x in [REX_X_L, REX_X_R); obstacle is OBS_W wide, OBS_H tall.
    localparam logic [15:0] REX_X_L = 16'd16;
    localparam logic [15:0] REX_X_R = 16'd32;
    localparam logic [15:0] OBS_W   = 16'd16;
    localparam logic [15:0] OBS_H   = 16'd26;

    // Obstacle step period for a level: base - level*step, floored at min_p.
    // The subtraction is done only when it cannot go below the floor, so the
    // 16-bit result never wraps.
    function automatic logic [15:0] obs_period(
        input logic [2:0]  lvl,
        input logic [15:0] base_p,
        input logic [15:0] step_p,
        input logic [15:0] min_p
    );
        logic [18:0] drop;
        drop = 19'(lvl) * 19'(step_p);
        if ((19'(min_p) + drop) >= 19'(base_p)) begin
            return min_p;
        end
        return base_p - drop[15:0];
    endfunction

endpackage

// File: rtl/step_divider.sv
// Loadable 16-bit down-counter producing a one-cycle strobe each time the
// count passes through zero. The strobe is registered, so it appears in the
// cycle the counter reloads.
module step_divider (
    input  logic        clk120kHz,
    input  logic        rst,
    input  logic [15:0] period,
    input  logic        load,
    input  logic        run,
    output logic        tick
);

    logic [15:0] count_reg;
    logic        tick_reg;

    // Count down while running; reload with the period presented at terminal count.
    always_ff @(posedge clk120kHz) begin
        if (rst) begin
            count_reg <= 16'd0;
            tick_reg  <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (load) begin
                count_reg <= period - 16'd1;
            end else if (run) begin
                if (count_reg == 16'd0) begin
                    count_reg <= period - 16'd1;
                    tick_reg  <= 1'b1;
                end else begin
                    count_reg <= count_reg - 16'd1;
                end
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/game_sequencer.sv
// Runner-game controller: game-state FSM, rex/obstacle step strobes,
// collision detection, scoring and speed levels.
// Optional build macro GAME_SEQ_HISCORE_EN keeps a best-score register that
// updates when a game ends; without it the hiscore port is tied to 0.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned DIV_REX      = 20000,
    parameter int unsigned DIV_OBS_BASE = 20000,
    parameter int unsigned DIV_OBS_STEP = 2000,
    parameter int unsigned DIV_OBS_MIN  = 8000,
    parameter int unsigned LEVEL_PTS    = 10,
    parameter int unsigned LEVEL_MAX    = 7,
    parameter int unsigned HOLD_STEPS   = 6,
    parameter int unsigned SCORE_MAX    = 9999
) (
    input  logic        clk120kHz,
    input  logic        rst,
    input  logic        in_up,
    input  logic [15:0] rex_y,
    input  logic [15:0] obs_left,
    output logic [1:0]  game_state,
    output logic        rex_step,
    output logic        obs_step,
    output logic        jump_req,
    output logic        hit,
    output logic [13:0] score,
    output logic [2:0]  level,
    output logic [13:0] hiscore
);

    game_state_t state_reg;
    logic        up_q_reg;
    logic [15:0] obs_left_q_reg;
    logic [13:0] score_reg;
    logic [2:0]  level_reg;
    logic [15:0] pts_reg;
    logic [15:0] hold_cnt_reg;
    logic        hit_reg;

    logic        up_edge;
    logic        playing;
    logic        start;
    logic        collide;
    logic        respawn;
    logic        hold_done;
    logic        rex_tick;
    logic        obs_tick;
    logic [15:0] obs_period_sel;

    assign up_edge = in_up & ~up_q_reg;
    assign playing = (state_reg == PLAYING);
    assign start   = (state_reg == INIT) && up_edge;

    // Overlap test; the x sum is widened to 17 bits so it cannot wrap.
    assign collide = playing
                  && (obs_left < REX_X_R)
                  && (({1'b0, obs_left} + {1'b0, OBS_W}) > {1'b0, REX_X_L})
                  && (rex_y < OBS_H);

    assign respawn   = playing && (obs_left > obs_left_q_reg);
    assign hold_done = (state_reg == HOLD) && rex_tick
                    && (hold_cnt_reg == 16'(HOLD_STEPS - 1));

    // A new game always starts from the level-0 period; otherwise the period
    // follows the live level and is sampled by the divider only at reload.
    assign obs_period_sel = start ? 16'(DIV_OBS_BASE)
                                  : obs_period(level_reg, 16'(DIV_OBS_BASE),
                                               16'(DIV_OBS_STEP), 16'(DIV_OBS_MIN));

    step_divider u_rex_div (
        .clk120kHz (clk120kHz),
        .rst       (rst),
        .period    (16'(DIV_REX)),
        .load      (start),
        .run       (playing || (state_reg == HOLD)),
        .tick      (rex_tick)
    );

    step_divider u_obs_div (
        .clk120kHz (clk120kHz),
        .rst       (rst),
        .period    (obs_period_sel),
        .load      (start),
        .run       (playing),
        .tick      (obs_tick)
    );

    // Button edge register and obstacle position history. The button register
    // comes out of reset as "pressed" so a button held through reset is not
    // taken as a start press until it is released and pressed again.
    always_ff @(posedge clk120kHz) begin
        if (rst) begin
            up_q_reg       <= 1'b1;
            obs_left_q_reg <= 16'd0;
        end else begin
            up_q_reg       <= in_up;
            obs_left_q_reg <= obs_left;
        end
    end

    // Game-state FSM with score, level and hold bookkeeping.
    always_ff @(posedge clk120kHz) begin
        if (rst) begin
            state_reg    <= INIT;
            score_reg    <= 14'd0;
            level_reg    <= 3'd0;
            pts_reg      <= 16'd0;
            hold_cnt_reg <= 16'd0;
            hit_reg      <= 1'b0;
        end else begin
            hit_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    if (up_edge) begin
                        state_reg <= PLAYING;
                        score_reg <= 14'd0;
                        level_reg <= 3'd0;
                        pts_reg   <= 16'd0;
                    end
                end
                PLAYING: begin
                    if (collide) begin
                        state_reg    <= HOLD;
                        hit_reg      <= 1'b1;
                        hold_cnt_reg <= 16'd0;
                    end else if (respawn && (score_reg != 14'(SCORE_MAX))) begin
                        score_reg <= score_reg + 14'd1;
                        if (pts_reg == 16'(LEVEL_PTS - 1)) begin
                            pts_reg <= 16'd0;
                            if (level_reg != 3'(LEVEL_MAX)) begin
                                level_reg <= level_reg + 3'd1;
                            end
                        end else begin
                            pts_reg <= pts_reg + 16'd1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        state_reg    <= OVER;
                        hold_cnt_reg <= 16'd0;
                    end else if (rex_tick) begin
                        hold_cnt_reg <= hold_cnt_reg + 16'd1;
                    end
                end
                OVER: begin
                    if (up_edge) begin
                        state_reg <= INIT;
                    end
                end
                default: state_reg <= INIT;
            endcase
        end
    end

`ifdef GAME_SEQ_HISCORE_EN
    logic [13:0] hiscore_reg;

    // Best score, captured as a game finishes holding.
    always_ff @(posedge clk120kHz) begin
        if (rst) begin
            hiscore_reg <= 14'd0;
        end else if (hold_done && (score_reg > hiscore_reg)) begin
            hiscore_reg <= score_reg;
        end
    end

    assign hiscore = hiscore_reg;
`else
    assign hiscore = 14'd0;
`endif

    assign game_state = state_reg;
    assign rex_step   = rex_tick & playing;
    assign obs_step   = obs_tick & playing;
    assign jump_req   = up_edge & playing;
    assign hit        = hit_reg;
    assign score      = score_reg;
    assign level      = level_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with shortened periods.
module tb_game_sequencer;

    logic        clk120kHz = 1'b0;
    logic        rst       = 1'b1;
    logic        in_up     = 1'b1;
    logic [15:0] rex_y     = 16'd36;
    logic [15:0] obs_left  = 16'd240;

    logic [1:0]  game_state;
    logic        rex_step;
    logic        obs_step;
    logic        jump_req;
    logic        hit;
    logic [13:0] score;
    logic [2:0]  level;
    logic [13:0] hiscore;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int entry  = 0;

    game_sequencer #(
        .DIV_REX      (10),
        .DIV_OBS_BASE (10),
        .DIV_OBS_STEP (2),
        .DIV_OBS_MIN  (4),
        .LEVEL_PTS    (2),
        .HOLD_STEPS   (2)
    ) dut (
        .clk120kHz  (clk120kHz),
        .rst        (rst),
        .in_up      (in_up),
        .rex_y      (rex_y),
        .obs_left   (obs_left),
        .game_state (game_state),
        .rex_step   (rex_step),
        .obs_step   (obs_step),
        .jump_req   (jump_req),
        .hit        (hit),
        .score      (score),
        .level      (level),
        .hiscore    (hiscore)
    );

    always #5 clk120kHz = ~clk120kHz;

    task automatic step();
        @(posedge clk120kHz);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Step until the next obs_step pulse; t is the cycle relative to game entry, -1 on timeout.
    task automatic wait_obs(output int t);
        t = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs_step) begin
                t = cyc - entry;
                break;
            end
        end
    endtask

    initial begin
        int          t_hit;
        int          t_over;
        int          first_tick;
        int          p1;
        int          p2;
        logic [13:0] exp_hi;
`ifdef GAME_SEQ_HISCORE_EN
        exp_hi = 14'd2;
`else
        exp_hi = 14'd0;
`endif

        // Reset with the button held
        rst = 1'b1; in_up = 1'b1;
        step(); step();
        chk("rst_state", 32'(game_state), 0);
        chk("rst_rex_step", 32'(rex_step), 0);
        chk("rst_obs_step", 32'(obs_step), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_jump", 32'(jump_req), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_hiscore", 32'(hiscore), 0);
        rst = 1'b0;
        step(); step(); step();
        chk("held_stays_init", 32'(game_state), 0);
        in_up = 1'b0;
        step();
        chk("release_init", 32'(game_state), 0);
        in_up = 1'b1;
        step();
        chk("start_playing", 32'(game_state), 1);
        chk("start_score", 32'(score), 0);
        entry = cyc;
        in_up = 1'b0;

        // Strobe timing at level 0: pulses at 10 and 20 cycles after entry
        for (int i = 1; i <= 21; i++) begin
            step();
            chk($sformatf("rex_step_c%0d", i), 32'(rex_step), ((i % 10) == 0) ? 1 : 0);
            chk($sformatf("obs_step_c%0d", i), 32'(obs_step), ((i % 10) == 0) ? 1 : 0);
        end

        // Two respawns with rex in the air
        obs_left = 16'd24;  step();
        obs_left = 16'd240; step();
        chk("score_1", 32'(score), 1);
        chk("level_0", 32'(level), 0);
        obs_left = 16'd24;  step();
        obs_left = 16'd240; step();
        chk("score_2", 32'(score), 2);
        chk("level_1", 32'(level), 1);

        // Old period still governs the pending count; new one from the next reload
        wait_obs(p1);
        chk("obs_pulse_old_period", 32'(p1), 30);
        wait_obs(p2);
        chk("obs_period_level1", 32'(p2 - p1), 8);

        // Jump request
        in_up = 1'b1;
        #1;
        chk("jump_req", 32'(jump_req), 1);
        step();
        chk("jump_once", 32'(jump_req), 0);
        chk("jump_keeps_playing", 32'(game_state), 1);
        in_up = 1'b0;

        // Collision
        rex_y = 16'd15; obs_left = 16'd24;
        step();
        t_hit = cyc - entry;
        chk("hit_pulse", 32'(hit), 1);
        chk("hit_state_hold", 32'(game_state), 2);
        chk("hit_score_kept", 32'(score), 2);
        chk("hit_rex_gated", 32'(rex_step), 0);
        step();
        chk("hit_one_cycle", 32'(hit), 0);

        // Hold lasts two rex terminal counts
        first_tick = ((t_hit + 9) / 10) * 10;
        t_over = first_tick + 10 + 1;
        for (int k = 0; k < 40; k++) begin
            if (game_state != 2'd2) break;
            chk("hold_strobes", {30'd0, rex_step, obs_step}, 0);
            step();
        end
        chk("over_state", 32'(game_state), 3);
        chk("over_time", 32'(cyc - entry), 32'(t_over));
        chk("over_score", 32'(score), 2);
        chk("over_level", 32'(level), 1);
        chk("over_hiscore", 32'(hiscore), 32'(exp_hi));

        // Back to INIT, score kept until the next start
        rex_y = 16'd36; obs_left = 16'd240;
        in_up = 1'b1; step();
        chk("over_to_init", 32'(game_state), 0);
        chk("init_keeps_score", 32'(score), 2);
        in_up = 1'b0; step();
        in_up = 1'b1; step();
        chk("restart_playing", 32'(game_state), 1);
        chk("restart_score", 32'(score), 0);
        chk("restart_level", 32'(level), 0);
        entry = cyc;
        in_up = 1'b0;

        // Collision boundaries
        rex_y = 16'd0; obs_left = 16'd32; step();
        chk("x32_no_hit", 32'(game_state), 1);
        obs_left = 16'd0; step();
        chk("x0_no_hit", 32'(game_state), 1);
        rex_y = 16'd26; obs_left = 16'd24; step();
        chk("y26_no_hit", 32'(game_state), 1);
        chk("y26_respawn_score", 32'(score), 1);

        // Respawn and collision in the same cycle
        rex_y = 16'd36; obs_left = 16'd8; step();
        chk("pre_tie_score", 32'(score), 1);
        rex_y = 16'd0; obs_left = 16'd20; step();
        chk("tie_hit", 32'(hit), 1);
        chk("tie_state", 32'(game_state), 2);
        chk("tie_no_score", 32'(score), 1);

        for (int k = 0; k < 40; k++) begin
            if (game_state == 2'd3) break;
            step();
        end
        chk("over2_state", 32'(game_state), 3);
        chk("over2_hiscore_kept", 32'(hiscore), 32'(exp_hi));

        // Third game, reset during HOLD
        in_up = 1'b1; step();
        in_up = 1'b0; step();
        rex_y = 16'd15; obs_left = 16'd24;
        in_up = 1'b1; step();
        chk("game3_playing", 32'(game_state), 1);
        in_up = 1'b0;
        step();
        chk("game3_hold", 32'(game_state), 2);
        rst = 1'b1;
        step();
        chk("midrst_state", 32'(game_state), 0);
        chk("midrst_score", 32'(score), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_hiscore", 32'(hiscore), 0);
        chk("midrst_hit", 32'(hit), 0);
        rst = 1'b0;
        step();
        chk("post_rst_init", 32'(game_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
